// File: rtl/spi_regbank_burst.sv
// SPI slave register bank: opcode/address framed bursts into an M x N register
// array with auto-increment and wrap, software ready flags and sticky error status.
module spi_regbank_burst #(
    parameter int M      = 320,
    parameter int N      = 8,
    parameter int ADDR_W = 16,
    parameter int NF     = 3
) (
    input  logic           SCLK,
    input  logic           RESET,
    input  logic           MOSI,
    input  logic           SS,
    output logic           MISO,
    output logic           busy,
    output logic [NF-1:0]  ready_out,
    output logic [M*N-1:0] all_data_out
);

    localparam int SH_W  = (ADDR_W > N) ? ((ADDR_W > 8) ? ADDR_W : 8) : ((N > 8) ? N : 8);
    localparam int CNT_W = $clog2(SH_W);
    localparam int AI_W  = (M > 1) ? $clog2(M) : 1;

    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(N - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(M - 1);

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_FLAGS  = 8'h05;
    localparam logic [7:0] OP_STATUS = 8'h06;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_FLAGS,
        S_STATUS,
        S_IGNORE
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [SH_W-1:0]    sh, sh_nx, shifted;
    logic [N-1:0]       rd_sh, rd_sh_nx;
    logic [ADDR_W-1:0]  addr, addr_nx;
    logic [ADDR_W-1:0]  addr_field, rd_addr;
    logic [N-1:0]       rd_word, wr_data;
    logic               is_read, is_read_nx;
    logic               inert, inert_nx;
    logic [2:0]         status, status_set;
    logic               status_clr;
    logic [NF-1:0]      flags_nx;
    logic               wr_en;
    logic [N-1:0]       regs [M];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a <= ADDR_TOP;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_TOP) ? '0 : a + 1'b1;
    endfunction

    assign shifted    = {sh[SH_W-2:0], MOSI};
    assign addr_field = shifted[ADDR_W-1:0];
    assign wr_data    = shifted[N-1:0];

    // Word to preload into the read shifter: first word at the address edge,
    // following words at the edge shifting out the previous LSB.
    assign rd_addr = (state == S_ADDR) ? addr_field : next_addr(addr);
    assign rd_word = ((state == S_RDATA && inert) || !in_range(rd_addr))
                     ? '0 : regs[rd_addr[AI_W-1:0]];

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        sh_nx      = sh;
        rd_sh_nx   = rd_sh;
        addr_nx    = addr;
        is_read_nx = is_read;
        inert_nx   = inert;
        flags_nx   = ready_out;
        status_set = '0;
        status_clr = 1'b0;
        wr_en      = 1'b0;
        if (SS) begin
            state_nx = S_CMD;
            cnt_nx   = '0;
            sh_nx    = '0;
            rd_sh_nx = '0;
            if (state != S_IGNORE && cnt != '0) status_set[2] = 1'b1;
        end else begin
            cnt_nx = cnt + 1'b1;
            sh_nx  = shifted;
            case (state)
                S_CMD: begin
                    if (cnt == CMD_LAST) begin
                        cnt_nx = '0;
                        sh_nx  = '0;
                        case (shifted[7:0])
                            OP_WRITE: begin
                                state_nx   = S_ADDR;
                                is_read_nx = 1'b0;
                            end
                            OP_READ: begin
                                state_nx   = S_ADDR;
                                is_read_nx = 1'b1;
                            end
                            OP_FLAGS:  state_nx = S_FLAGS;
                            OP_STATUS: begin
                                state_nx = S_STATUS;
                                rd_sh_nx = N'(status);
                            end
                            default: begin
                                state_nx      = S_IGNORE;
                                status_set[0] = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (cnt == ADDR_LAST) begin
                        cnt_nx   = '0;
                        sh_nx    = '0;
                        addr_nx  = addr_field;
                        inert_nx = !in_range(addr_field);
                        if (!in_range(addr_field)) status_set[1] = 1'b1;
                        state_nx = is_read ? S_RDATA : S_WDATA;
                        rd_sh_nx = rd_word;
                    end
                end
                S_WDATA: begin
                    if (cnt == WORD_LAST) begin
                        cnt_nx  = '0;
                        sh_nx   = '0;
                        wr_en   = !inert;
                        addr_nx = next_addr(addr);
                    end
                end
                S_RDATA: begin
                    rd_sh_nx = {rd_sh[N-2:0], 1'b0};
                    if (cnt == WORD_LAST) begin
                        cnt_nx   = '0;
                        sh_nx    = '0;
                        addr_nx  = next_addr(addr);
                        rd_sh_nx = rd_word;
                    end
                end
                S_FLAGS: begin
                    if (cnt == WORD_LAST) begin
                        cnt_nx   = '0;
                        sh_nx    = '0;
                        flags_nx = shifted[NF-1:0];
                        state_nx = S_IGNORE;
                    end
                end
                S_STATUS: begin
                    rd_sh_nx = {rd_sh[N-2:0], 1'b0};
                    if (cnt == WORD_LAST) begin
                        cnt_nx     = '0;
                        sh_nx      = '0;
                        status_clr = 1'b1;
                        state_nx   = S_IGNORE;
                    end
                end
                default: begin
                    cnt_nx = '0;
                    sh_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state <= S_CMD;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A new error raised on the clearing edge survives the clear.
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            sh        <= '0;
            rd_sh     <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            inert     <= 1'b0;
            status    <= '0;
            ready_out <= '0;
        end else begin
            sh        <= sh_nx;
            rd_sh     <= rd_sh_nx;
            addr      <= addr_nx;
            is_read   <= is_read_nx;
            inert     <= inert_nx;
            status    <= (status & ~{3{status_clr}}) | status_set;
            ready_out <= flags_nx;
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < M; k++) regs[k] <= '0;
        end else if (wr_en) begin
            regs[addr[AI_W-1:0]] <= wr_data;
        end
    end

    for (genvar k = 0; k < M; k++) begin : g_out
        assign all_data_out[k*N +: N] = regs[k];
    end

    assign MISO = (state == S_RDATA || state == S_STATUS) ? rd_sh[N-1] : 1'b0;
    assign busy = (state != S_CMD) || (cnt != '0);

endmodule

// File: tb/tb_spi_regbank_burst.sv
// Directed plus randomized bench for spi_regbank_burst against a frame-level
// model of the register array, flags and sticky status.
module tb_spi_regbank_burst;

  localparam int M  = 320;
  localparam int N  = 8;
  localparam int NF = 3;

  logic           SCLK = 1'b0;
  logic           RESET = 1'b1;
  logic           MOSI = 1'b0;
  logic           SS = 1'b1;
  logic           MISO;
  logic           busy;
  logic [NF-1:0]  ready_out;
  logic [M*N-1:0] all_data_out;

  int n_vec = 0;
  int n_bad = 0;
  logic done = 1'b0;

  logic [7:0]    m_regs [M];
  logic [NF-1:0] m_flags;
  logic [2:0]    m_status;

  spi_regbank_burst #(.M(M), .N(N), .ADDR_W(16), .NF(NF)) dut (
    .SCLK(SCLK),
    .RESET(RESET),
    .MOSI(MOSI),
    .SS(SS),
    .MISO(MISO),
    .busy(busy),
    .ready_out(ready_out),
    .all_data_out(all_data_out)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_bad_reg();
    for (int k = 0; k < M; k++)
      if (all_data_out[k*N +: N] !== m_regs[k]) return k;
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < M; k++) m_regs[k] = 8'h00;
    m_flags  = '0;
    m_status = '0;
  endtask

  // Drive one bit for the next rising edge; r is what the master samples there.
  task automatic send_bit(input logic b, output logic r);
    @(negedge SCLK);
    SS   = 1'b0;
    MOSI = b;
    #1 r = MISO;
    @(posedge SCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic [7:0] r);
    logic x;
    for (int b = 7; b >= 0; b--) begin
      send_bit(v[b], x);
      r[b] = x;
    end
  endtask

  task automatic send_addr(input logic [15:0] a);
    logic x;
    for (int b = 15; b >= 0; b--) send_bit(a[b], x);
  endtask

  task automatic ss_high();
    @(negedge SCLK);
    SS   = 1'b1;
    MOSI = 1'b0;
    @(posedge SCLK);
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_miso", MISO, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    SS    = 1'b1;
    MOSI  = 1'b0;
    RESET = 1'b1;
    model_clear();
    repeat (cycles) @(posedge SCLK);
    @(negedge SCLK);
    RESET = 1'b0;
    @(posedge SCLK);
    #1;
  endtask

  task automatic do_write(input int a, input logic [31:0] words, input int n);
    logic [7:0] d;
    logic r;
    int p;
    send_byte(8'h02, d);
    send_addr(16'(a));
    if (a >= M) m_status[1] = 1'b1;
    check("wr_busy", busy, 1'b1);
    p = a;
    for (int i = 0; i < n; i++) begin
      d = words[31-8*i -: 8];
      for (int b = 7; b >= 1; b--) send_bit(d[b], r);
      check("wr_pre_commit", first_bad_reg(), -1);
      send_bit(d[0], r);
      if (a < M) begin
        m_regs[p] = d;
        check("wr_word", all_data_out[p*N +: N], d);
        p = (p + 1) % M;
      end
      check("wr_commit", first_bad_reg(), -1);
    end
    ss_high();
  endtask

  task automatic do_read(input int a, input int n);
    logic [7:0] d, rd, exp;
    logic r;
    int p;
    send_byte(8'h03, d);
    send_addr(16'(a));
    if (a >= M) m_status[1] = 1'b1;
    check("rd_busy", busy, 1'b1);
    p = a;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        send_bit(1'($urandom), r);
        rd[b] = r;
      end
      exp = (a < M) ? m_regs[p] : 8'h00;
      check("rd_word", rd, exp);
      if (a < M) p = (p + 1) % M;
    end
    ss_high();
  endtask

  task automatic do_flags(input logic [7:0] v);
    logic [7:0] d;
    logic r;
    send_byte(8'h05, d);
    for (int b = 7; b >= 1; b--) send_bit(v[b], r);
    check("flags_pre", ready_out, m_flags);
    send_bit(v[0], r);
    m_flags = v[NF-1:0];
    check("flags", ready_out, m_flags);
    ss_high();
  endtask

  task automatic do_status();
    logic [7:0] d, rd;
    send_byte(8'h06, d);
    send_byte(8'h00, rd);
    check("status", rd, {5'b0, m_status});
    m_status = '0;
    ss_high();
  endtask

  task automatic do_bad(input logic [7:0] op, input int extra);
    logic [7:0] d;
    logic r;
    send_byte(op, d);
    for (int i = 0; i < extra; i++) send_bit(1'($urandom), r);
    m_status[0] = 1'b1;
    ss_high();
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, M - 1));
      1:       return M - 1 - int'($urandom_range(0, 1));
      2:       return M + int'($urandom_range(0, 50));
      default: return int'($urandom_range(0, 5));
    endcase
  endfunction

  initial begin
    #200000;
    if (!done) begin
      $error("TIMEOUT: stimulus did not complete");
      $finish;
    end
  end

  initial begin
    logic [7:0] d, op;
    logic r;

    model_clear();
    repeat (5) @(posedge SCLK);
    #1;
    check("rst_miso", MISO, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready_out, 3'b000);
    check("rst_regs", first_bad_reg(), -1);
    @(negedge SCLK);
    RESET = 1'b0;
    @(posedge SCLK);
    #1;

    do_write(0, 32'hA55A_0000, 2);
    check("reg0", all_data_out[7:0], 8'hA5);
    check("reg1", all_data_out[15:8], 8'h5A);

    do_write(319, 32'h1122_0000, 2);
    check("reg319", all_data_out[319*8 +: 8], 8'h11);
    check("reg0_wrap", all_data_out[7:0], 8'h22);
    do_read(319, 2);

    do_flags(8'h05);
    check("ready_101", ready_out, 3'b101);
    do_reset(3);
    check("ready_rst", ready_out, 3'b000);

    do_bad(8'h7E, 3);
    do_write(400, 32'hFF00_0000, 1);
    check("range_regs", first_bad_reg(), -1);
    do_status();
    do_status();

    // Abort a write after 5 data bits.
    send_byte(8'h02, d);
    send_addr(16'd4);
    for (int b = 0; b < 5; b++) send_bit(1'b1, r);
    ss_high();
    m_status[2] = 1'b1;
    check("abort_reg4", all_data_out[4*8 +: 8], m_regs[4]);
    do_status();

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 4))
        0: do_write(pick_addr(), $urandom, int'($urandom_range(1, 4)));
        1: do_read(pick_addr(), int'($urandom_range(1, 3)));
        2: do_flags(8'($urandom));
        3: begin
          do op = 8'($urandom); while (op inside {8'h02, 8'h03, 8'h05, 8'h06});
          do_bad(op, int'($urandom_range(0, 5)));
        end
        default: do_status();
      endcase
    end
    do_status();
    check("rand_regs", first_bad_reg(), -1);

    // Reset in the middle of a read word.
    do_write(0, 32'h8100_0000, 1);
    send_byte(8'h03, d);
    send_addr(16'd0);
    @(negedge SCLK);
    #1;
    check("rd_msb", MISO, 1'b1);
    #2 RESET = 1'b1;
    model_clear();
    #1;
    check("mid_rst_miso", MISO, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_regs", first_bad_reg(), -1);
    SS = 1'b1;
    repeat (3) @(posedge SCLK);
    @(negedge SCLK);
    RESET = 1'b0;
    @(posedge SCLK);
    #1;
    do_read(0, 1);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
